// File: rtl/alu_cmd_driver_if.sv
// Request/response handshake bundle between a command source and the ALU
// command driver. The master is the command source; the slave is the driver.
interface alu_cmd_driver_if #(
    parameter int WIDTH = 5
);
    // Request channel
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [1:0]       req_mode;
    logic [2:0]       req_a_op;
    logic [1:0]       req_b_op;

    // Response channel
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH:0]   rsp_c;
    logic             rsp_err;
    logic             rsp_mismatch;

    modport master (
        output req_valid, req_a, req_b, req_mode, req_a_op, req_b_op,
        input  req_ready,
        input  rsp_valid, rsp_c, rsp_err, rsp_mismatch,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_a, req_b, req_mode, req_a_op, req_b_op,
        output req_ready,
        output rsp_valid, rsp_c, rsp_err, rsp_mismatch,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_cmd_driver.sv
// ALU command driver: accepts one request at a time, pulses the ALU enable
// for a single cycle, captures the ALU's registered result/error, compares
// the error against a locally predicted value and returns a response.
module alu_cmd_driver #(
    parameter int WIDTH = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_cmd_driver_if.slave    bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic               alu_en,
    output logic               alu_a_en,
    output logic               alu_b_en,
    output logic [2:0]         alu_a_op,
    output logic [1:0]         alu_b_op,
    input  logic [WIDTH:0]     alu_c,
    input  logic               alu_error,
    output logic [15:0]        txn_count,
    output logic [7:0]         mismatch_count
);

    // Most negative signed operand; the ALU flags it as an error.
    localparam logic [WIDTH-1:0] MIN_OPERAND = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic             w_alu_en;
    logic             w_accept;
    logic             w_rsp_done;
    logic             w_pred_err;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_mode;
    logic [2:0]       r_a_op;
    logic [1:0]       r_b_op;
    logic             r_pred_err;

    logic [WIDTH:0]   r_rsp_c;
    logic             r_rsp_err;
    logic             r_rsp_mismatch;
    logic [15:0]      r_txn_count;
    logic [7:0]       r_mismatch_count;

    assign w_accept   = (r_state == S_IDLE) && bus.req_valid;
    assign w_rsp_done = (r_state == S_RESP) && bus.rsp_ready;

    // Error the ALU is expected to raise for the incoming request.
    assign w_pred_err = (bus.req_a == MIN_OPERAND) ||
                        (bus.req_b == MIN_OPERAND) ||
                        ((bus.req_mode == 2'b01) && (bus.req_a_op == 3'd7)) ||
                        ((bus.req_mode == 2'b10) && (bus.req_b_op == 2'd3));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and state-decoded handshake/enable outputs.
    always_comb begin
        w_state_next = r_state;
        w_req_ready  = 1'b0;
        w_rsp_valid  = 1'b0;
        w_alu_en     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_alu_en     = 1'b1;
                w_state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
                w_state_next = S_RESP;
            end
            S_RESP: begin
                w_rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Request registers; these also hold the ALU drive values between issues.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a        <= '0;
            r_b        <= '0;
            r_mode     <= '0;
            r_a_op     <= '0;
            r_b_op     <= '0;
            r_pred_err <= 1'b0;
        end else if (w_accept) begin
            r_a        <= bus.req_a;
            r_b        <= bus.req_b;
            r_mode     <= bus.req_mode;
            r_a_op     <= bus.req_a_op;
            r_b_op     <= bus.req_b_op;
            r_pred_err <= w_pred_err;
        end
    end

    // Capture the ALU's registered outputs one cycle after the enable pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_c        <= '0;
            r_rsp_err      <= 1'b0;
            r_rsp_mismatch <= 1'b0;
        end else if (r_state == S_CAPTURE) begin
            r_rsp_c        <= alu_c;
            r_rsp_err      <= alu_error;
            r_rsp_mismatch <= alu_error ^ r_pred_err;
        end
    end

    // Completed-response counter (wraps) and mismatch counter (saturates).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_txn_count      <= '0;
            r_mismatch_count <= '0;
        end else if (w_rsp_done) begin
            r_txn_count <= r_txn_count + 16'd1;
            if (r_rsp_mismatch && (r_mismatch_count != 8'hFF)) begin
                r_mismatch_count <= r_mismatch_count + 8'd1;
            end
        end
    end

    assign bus.req_ready    = w_req_ready;
    assign bus.rsp_valid    = w_rsp_valid;
    assign bus.rsp_c        = r_rsp_c;
    assign bus.rsp_err      = r_rsp_err;
    assign bus.rsp_mismatch = r_rsp_mismatch;

    assign alu_en         = w_alu_en;
    assign alu_a          = r_a;
    assign alu_b          = r_b;
    assign alu_a_en       = r_mode[0];
    assign alu_b_en       = r_mode[1];
    assign alu_a_op       = r_a_op;
    assign alu_b_op       = r_b_op;
    assign txn_count      = r_txn_count;
    assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: a stand-in ALU registers results on alu_en,
// and a transaction-level model predicts every response and counter.
module tb_alu_cmd_driver;
    localparam int WIDTH = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_cmd_driver_if #(.WIDTH(WIDTH)) bus ();

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_en;
    logic             alu_a_en;
    logic             alu_b_en;
    logic [2:0]       alu_a_op;
    logic [1:0]       alu_b_op;
    logic [WIDTH:0]   alu_c = '0;
    logic             alu_error = 1'b0;
    logic [15:0]      txn_count;
    logic [7:0]       mismatch_count;

    alu_cmd_driver #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_en         (alu_en),
        .alu_a_en       (alu_a_en),
        .alu_b_en       (alu_b_en),
        .alu_a_op       (alu_a_op),
        .alu_b_op       (alu_b_op),
        .alu_c          (alu_c),
        .alu_error      (alu_error),
        .txn_count      (txn_count),
        .mismatch_count (mismatch_count)
    );

    // Stand-in ALU behaviour: returns {ok, err, c}. ok=0 means the ALU holds C.
    function automatic logic [7:0] alu_calc(input logic signed [4:0] a,
                                            input logic signed [4:0] b,
                                            input logic [1:0] mode,
                                            input logic [2:0] aop,
                                            input logic [1:0] bop);
        logic signed [5:0] c;
        logic ok;
        logic err;
        c  = '0;
        ok = 1'b1;
        case (mode)
            2'b01: case (aop)
                3'd0: c = a + b;
                3'd1: c = a - b;
                3'd2: c = a ^ b;
                3'd3: c = a & b;
                3'd4: c = a | b;
                3'd5: c = ~(a & b);
                3'd6: c = ~(a ^ b);
                default: ok = 1'b0;
            endcase
            2'b10: case (bop)
                2'd0: c = ~(a & b);
                2'd1: c = a + b;
                2'd2: c = b - a;
                default: ok = 1'b0;
            endcase
            2'b11: case (bop)
                2'd0: c = a ^ b;
                2'd1: c = ~(a ^ b);
                2'd2: c = a - 6'sd1;
                default: c = b + 6'sd2;
            endcase
            default: ok = 1'b0;
        endcase
        err = (a == 5'sb10000) || (b == 5'sb10000) || (!ok && mode != 2'b00);
        return {ok, err, 6'(c)};
    endfunction

    // When set, the stand-in ALU hides its error on mode 01 / a_op 7.
    logic       force_no_err = 1'b0;
    logic [7:0] alu_res;
    assign alu_res = alu_calc(alu_a, alu_b, {alu_b_en, alu_a_en}, alu_a_op, alu_b_op);

    always @(posedge clk) begin
        if (alu_en) begin
            if (alu_res[7]) alu_c <= alu_res[5:0];
            alu_error <= alu_res[6] & ~(force_no_err && {alu_b_en, alu_a_en} == 2'b01 && alu_a_op == 3'd7);
        end
    end

    int n_cmp  = 0;
    int n_fail = 0;
    int n_txn  = 0;

    // Transaction-level model state.
    logic [5:0]  model_c   = '0;
    logic [15:0] model_txn = '0;
    logic [7:0]  model_mm  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full request/response transaction; hold = cycles of response backpressure.
    task automatic do_txn(input logic [4:0] a, input logic [4:0] b, input logic [1:0] mode,
                          input logic [2:0] aop, input logic [1:0] bop, input int hold);
        logic [7:0] r;
        logic       pred;
        logic       exp_err;
        logic       exp_mm;
        r = alu_calc(a, b, mode, aop, bop);
        if (r[7]) model_c = r[5:0];
        pred    = (a == 5'b10000) || (b == 5'b10000) ||
                  (mode == 2'b01 && aop == 3'd7) || (mode == 2'b10 && bop == 2'd3);
        exp_err = r[6] & ~(force_no_err && mode == 2'b01 && aop == 3'd7);
        exp_mm  = exp_err ^ pred;

        bus.req_valid = 1'b1;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_mode  = mode;
        bus.req_a_op  = aop;
        bus.req_b_op  = bop;
        bus.rsp_ready = (hold == 0);
        chk("idle_req_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        if (hold == 0) bus.req_valid = 1'b0;
        // ISSUE
        chk("issue_alu_en", 32'(alu_en), 32'd1);
        chk("issue_alu_a", 32'(alu_a), 32'(a));
        chk("issue_alu_b", 32'(alu_b), 32'(b));
        chk("issue_en_bits", 32'({alu_b_en, alu_a_en}), 32'(mode));
        chk("issue_ops", 32'({alu_a_op, alu_b_op}), 32'({aop, bop}));
        chk("issue_req_ready", 32'(bus.req_ready), 32'd0);
        chk("issue_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        // CAPTURE
        chk("capture_alu_en", 32'(alu_en), 32'd0);
        chk("capture_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        // RESP
        chk("resp_valid", 32'(bus.rsp_valid), 32'd1);
        chk("resp_c", 32'(bus.rsp_c), 32'(model_c));
        chk("resp_err", 32'(bus.rsp_err), 32'(exp_err));
        chk("resp_mismatch", 32'(bus.rsp_mismatch), 32'(exp_mm));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            chk("bp_rsp_c", 32'(bus.rsp_c), 32'(model_c));
            chk("bp_rsp_flags", 32'({bus.rsp_err, bus.rsp_mismatch}), 32'({exp_err, exp_mm}));
            chk("bp_alu_en", 32'(alu_en), 32'd0);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        model_txn = model_txn + 16'd1;
        if (exp_mm && model_mm != 8'hFF) model_mm = model_mm + 8'd1;
        chk("done_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("done_req_ready", 32'(bus.req_ready), 32'd1);
        chk("txn_count", 32'(txn_count), 32'(model_txn));
        chk("mismatch_count", 32'(mismatch_count), 32'(model_mm));
        n_txn++;
        $display("txn %0d: a=%0d b=%0d mode=%b aop=%0d bop=%0d hold=%0d -> c=%0d err=%b mm=%b txns=%0d mms=%0d",
                 n_txn, $signed(a), $signed(b), mode, aop, bop, hold,
                 $signed(bus.rsp_c), bus.rsp_err, bus.rsp_mismatch, txn_count, mismatch_count);
    endtask

    // Global time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] ra;
        logic [4:0] rb;
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_mode  = '0;
        bus.req_a_op  = '0;
        bus.req_b_op  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp", 32'({bus.rsp_c, bus.rsp_err, bus.rsp_mismatch}), 32'd0);
        chk("rst_alu_ctl", 32'({alu_en, alu_a_en, alu_b_en, alu_a_op, alu_b_op}), 32'd0);
        chk("rst_alu_ops", 32'({alu_a, alu_b}), 32'd0);
        chk("rst_counters", 32'({txn_count, mismatch_count}), 32'd0);

        // Directed cases: ADD, illegal opcode (ALU holds), min operand
        do_txn(5'd7, 5'd5, 2'b01, 3'd0, 2'd0, 0);
        chk("add_c_is_12", 32'(bus.rsp_c), 32'd12);
        do_txn(5'd1, 5'd1, 2'b10, 3'd0, 2'd3, 0);
        chk("illegal_holds_12", 32'(bus.rsp_c), 32'd12);
        do_txn(5'b10000, 5'd3, 2'b11, 3'd0, 2'd3, 0);
        chk("minop_c_is_5", 32'(bus.rsp_c), 32'd5);

        // Backpressure with req_valid held high
        do_txn(5'd4, 5'd2, 2'b01, 3'd1, 2'd0, 5);

        // Forced mismatch
        force_no_err = 1'b1;
        do_txn(5'd2, 5'd3, 2'b01, 3'd7, 2'd0, 0);
        force_no_err = 1'b0;

        // Randomized transactions
        for (int i = 0; i < 40; i++) begin
            ra = ($urandom_range(0, 6) == 0) ? 5'b10000 : 5'($urandom);
            rb = ($urandom_range(0, 6) == 0) ? 5'b10000 : 5'($urandom);
            force_no_err = 1'($urandom_range(0, 1));
            do_txn(ra, rb, 2'($urandom), 3'($urandom), 2'($urandom), $urandom_range(0, 2));
        end
        force_no_err = 1'b0;

        // Reset while in ISSUE: dropped transaction, ALU still registered it
        bus.req_valid = 1'b1;
        bus.req_a     = 5'd3;
        bus.req_b     = 5'd6;
        bus.req_mode  = 2'b11;
        bus.req_a_op  = 3'd0;
        bus.req_b_op  = 2'd0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("rstissue_alu_en_before", 32'(alu_en), 32'd1);
        rst           = 1'b1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        rst       = 1'b0;
        model_c   = 6'd5;
        model_txn = '0;
        model_mm  = '0;
        chk("rstissue_alu_en_after", 32'(alu_en), 32'd0);
        chk("rstissue_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rstissue_counters", 32'({txn_count, mismatch_count}), 32'd0);
        chk("rstissue_alu_a", 32'(alu_a), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("rstissue_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        // Mode 00 holds C, which the dropped transaction set to 3^6 = 5
        do_txn(5'd9, 5'd1, 2'b00, 3'd2, 2'd1, 0);
        chk("post_rst_hold_c", 32'(bus.rsp_c), 32'd5);

        // Mismatch counter saturation
        force_no_err = 1'b1;
        for (int i = 0; i < 300; i++) begin
            do_txn(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)), 2'b01, 3'd7, 2'd0, 0);
        end
        force_no_err = 1'b0;
        chk("mismatch_saturated", 32'(mismatch_count), 32'd255);
        chk("txn_after_sat", 32'(txn_count), 32'd301);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Initiator-side command driver for the ALU datapath. Accepts operation requests on a valid/ready interface and drives the ALU's operand and control inputs with a single enable pulse. It then captures the ALU's registered result and error flag and returns them on a valid/ready response interface. The driver also checks the ALU's error flag against its own prediction and keeps transaction and mismatch counters.

## Interface
- `WIDTH`, 5, operand width; ALU result width is `WIDTH+1`.
- `clk` in 1: single clock; the ALU shares this clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: driver can accept a request.
- `req_a`, `req_b` in WIDTH: signed operands.
- `req_mode` in 2: `{b_en,a_en}` operation select.
- `req_a_op` in 3, `req_b_op` in 2: opcodes.
- `alu_a`, `alu_b` out WIDTH: drive ALU `A`/`B`.
- `alu_en`, `alu_a_en`, `alu_b_en` out 1: drive ALU `ALU_en`/`a_en`/`b_en`.
- `alu_a_op` out 3, `alu_b_op` out 2: drive ALU opcodes.
- `alu_c` in WIDTH+1: ALU registered result `C`.
- `alu_error` in 1: ALU registered `error_flag`.
- `rsp_valid` out 1, `rsp_ready` in 1: response handshake.
- `rsp_c` out WIDTH+1: captured result.
- `rsp_err` out 1: captured ALU error flag.
- `rsp_mismatch` out 1: `rsp_err` differs from the predicted error.
- `txn_count` out 16: completed responses; wraps.
- `mismatch_count` out 8: responses with mismatch; saturates at 255.

## Operation
- FSM states:
  - IDLE: `req_ready=1`. On `req_valid`, register all request fields and compute `pred_err`, then go to ISSUE.
  - ISSUE: one cycle. `alu_en=1`, `alu_a_en/alu_b_en` from `req_mode`, operands and opcodes from the request registers. Go to CAPTURE.
  - CAPTURE: one cycle. Register `alu_c` into `rsp_c` and `alu_error` into `rsp_err`. Set `rsp_mismatch = alu_error ^ pred_err`. Go to RESP.
  - RESP: `rsp_valid=1`. On `rsp_ready`, increment `txn_count`, increment `mismatch_count` if `rsp_mismatch` (saturating), and go to IDLE.
- `pred_err = 1` when any of the following holds:
  - `req_a` or `req_b` equals -2^(WIDTH-1);
  - `req_mode==01` and `req_a_op==7`;
  - `req_mode==10` and `req_b_op==3`.
- Mode 00 and the illegal opcodes are forwarded unchanged. The ALU holds its previous C in these cases; the driver does not filter them.
- `alu_en=0` in all states except ISSUE.
- `alu_a`, `alu_b`, `alu_a_en`, `alu_b_en` and the opcode outputs hold their last registered values outside ISSUE.
- Only one transaction is outstanding; there is no request buffering.

## Timing
- Request accepted at edge E0 (`req_valid & req_ready`).
  - E0..E1: ISSUE; the ALU registers its result at E1.
  - E1..E2: CAPTURE.
  - `rsp_valid` rises after E2, i.e. 3 cycles after acceptance.
- Minimum request-to-request spacing is 4 cycles, achieved with `rsp_ready` held high.
- While `rsp_valid=1` and `rsp_ready=0`: `rsp_c`, `rsp_err` and `rsp_mismatch` are stable, and `req_ready=0`.
- `req_ready` is combinational from state (IDLE only). It does not depend on `req_valid`.
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`. All of the following are 0:
  - `rsp_c`, `rsp_err`, `rsp_mismatch`;
  - `alu_en`, `alu_a_en`, `alu_b_en`, `alu_a`, `alu_b`, `alu_a_op`, `alu_b_op`;
  - `txn_count`, `mismatch_count`.
- Reset mid-transaction (any state): the in-flight transaction is dropped with no response. If reset is asserted during ISSUE, `alu_en` is 0 from the following cycle; the ALU keeps whatever it registered.
- `txn_count` wraps 0xFFFF→0. `mismatch_count` holds at 255.
- An ALU error response still completes normally; `rsp_err` only reports it.

## Test plan
- ADD: `req_a=7`, `req_b=5`, mode 01, `a_op` 000, `rsp_ready=1` → `rsp_valid` 3 cycles after acceptance, `rsp_c=12`, `rsp_err=0`, `rsp_mismatch=0`, `txn_count=1`, `alu_en` high exactly 1 cycle.
- Min operand: `req_a=-16`, `req_b=3`, mode 11, `b_op` 11 → `rsp_c=5`, `rsp_err=1`, `rsp_mismatch=0`.
- Illegal opcode after the ADD case: mode 10, `b_op` 3, `A=1`, `B=1` → `rsp_c=12` (ALU holds), `rsp_err=1`, `rsp_mismatch=0`.
- Backpressure: `rsp_ready=0` for 5 cycles with `req_valid=1` → response fields stable, `req_ready=0` throughout. The next request is accepted only after the `rsp_ready` handshake.
- Mismatch: model forces `alu_error=0` on mode 01, `a_op` 7 → `rsp_mismatch=1`, `mismatch_count` increments. 300 such transactions → `mismatch_count=255`.
- Reset in ISSUE: assert `rst` 1 cycle → no `rsp_valid`, counters 0, `req_ready=1` on the cycle after reset deasserts.
